clk_div_ctrl: RTL and testbench
===============================

# clk_div_ctrl

Runtime-programmable clock divider controller for the FFT clocking path. It generates a 50%-duty divided clock `clk_out` for any integer ratio from 2 to 2^WIDTH-1, odd or even. Stage logic gets a one-cycle `tick` strobe at the start of every divided period. A valid/ready handshake accepts ratio changes and applies them glitch-free, only at a period boundary.

## Interface
- `WIDTH`, default 4: width of the divide ratio and the period counter.
- `N_RESET`, default 5: divide ratio loaded at reset. Must be in 2..2^WIDTH-1.
- `clk`, input, 1: source clock. Reset is synchronous, active-high, sampled on `posedge clk`.
- `reset`, input, 1: synchronous, active-high reset.
- `req_valid`, input, 1: a new ratio is offered on `req_div`.
- `req_div`, input, WIDTH: requested divide ratio.
- `req_ready`, output, 1: controller can accept a request.
- `req_err`, output, 1: one-cycle pulse; the accepted request had `req_div` < 2 and was discarded.
- `cur_div`, output, WIDTH: ratio currently in effect.
- `clk_out`, output, 1: divided clock.
- `tick`, output, 1: high for the single `clk` cycle in which the period counter equals 0.

## Operation
- **State**
  - `count`: WIDTH-bit period counter, range 0..`cur_div`-1.
  - `pend`: 1-bit change-pending flag.
  - `pend_div`: WIDTH-bit pending ratio.
  - `hi_p`: posedge high-phase flop.
  - `hi_n`: negedge copy of `hi_p`.
- **Reset values**
  - `count` = `N_RESET`-1, so the first edge after reset starts a full period.
  - `cur_div` = `N_RESET`; `pend` = 0; `hi_p` = `hi_n` = 0.
  - `clk_out` = 0, `tick` = 0, `req_ready` = 1, `req_err` = 0.
  - `hi_n` is also cleared on the negedge while `reset` is high.
- **Counting**
  - Boundary is `count` == `cur_div`-1.
  - `count_next` = 0 at a boundary, otherwise `count`+1.
  - `h` = `div_eff` >> 1, where `div_eff` is the ratio in effect for `count_next`.
  - `hi_p` <= (`count_next` < `h`).
  - `tick` <= (`count_next` == 0).
- **Output**
  - `hi_n` <= `hi_p` on `negedge clk`.
  - `clk_out` = `hi_p` | (`div_eff`[0] & `hi_n`).
  - Even ratio N: `clk_out` is high for N/2 cycles.
  - Odd ratio N: `clk_out` is high for (N-1)/2 + 0.5 cycles.
  - The rising edge of `clk_out` is coincident with `tick`.
- **Handshake**
  - `req_ready` = !`pend`. A transfer occurs on `req_valid` & `req_ready` at a posedge.
  - `req_div` >= 2: `pend` <= 1 and `pend_div` <= `req_div`.
  - `req_div` < 2: `req_err` pulses the next cycle; `pend` and `cur_div` are unchanged.
- **Apply**
  - At a boundary with `pend` = 1: `cur_div` <= `pend_div`, `pend` <= 0, `count` <= 0.
  - `hi_p` and `tick` for the new period use the new ratio.
  - Divided-clock periods are never truncated or stretched.
- **Boundary conditions**
  - A request accepted in a boundary cycle sees registered `pend` = 0 in that cycle. It is applied at the following boundary, not the current one.
  - Requesting a ratio equal to `cur_div` completes the handshake normally with no visible change.
  - Reset mid-period or mid-handshake discards `pend` and restores `N_RESET` on the next edge.

## Timing
- `tick` and `hi_p` are registered, with zero cycles of combinational path from `count`.
- `clk_out` has a half-cycle path through `hi_n` for odd ratios only.
- Request latency:
  - `req_ready` falls the cycle after acceptance.
  - The new ratio takes effect on the first `tick` after the current period ends.
  - `req_ready` rises in the same cycle as that `tick`.
  - Worst case: `cur_div` cycles from acceptance to effect.
- `cur_div` changes in the cycle the new period begins, aligned with `tick`.
- After reset deasserts, the first `tick` and `clk_out` rise occur one cycle later.

## Configuration
- **`CLK_DIV_CTRL_GATE_EN` defined:** adds input port `gate_en` (1 bit).
  - While `gate_en` = 0, the block freezes at the next boundary:
    - `count` holds at `cur_div`-1;
    - `hi_p` = 0 and `clk_out` = 0;
    - no `tick`.
  - Pending changes still apply at the freeze boundary.
  - When `gate_en` returns to 1, the next edge starts a full period with `tick`.
  - Gating never cuts a period short.
- **Not defined:** the port is absent and the divider runs continuously.

## Test plan
- **Reset defaults:** release reset with `N_RESET`=5.
  - `tick` every 5 cycles.
  - `clk_out` high 2.5 cycles and low 2.5 cycles.
  - `cur_div`=5, `req_ready`=1.
- **Ratio change:** request 4 mid-period at `count`=2.
  - `req_ready` low until the next boundary.
  - Then `tick` every 4 cycles, `clk_out` 2 high / 2 low, `cur_div`=4.
- **Boundary collision:** request 3 accepted exactly in a boundary cycle.
  - One more 5-cycle period, then the 3-cycle period (1.5 high / 1.5 low).
- **Invalid ratio:** request `req_div`=1.
  - `req_err` pulses once; `cur_div` stays 5; `tick` spacing unchanged.
- **Reset mid-operation:** assert reset mid-period with a pending change to 7.
  - `clk_out`=0 and `pend` cleared.
  - After release, 5-cycle periods resume.
- **Gating** (with `CLK_DIV_CTRL_GATE_EN`): drop `gate_en` mid-period.
  - The current period completes, then `clk_out` stays low with no `tick`.
  - When `gate_en` is raised, `tick` follows on the next cycle.

Source files
------------

// File: rtl/clk_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_ctrl
// Brief    : Runtime-programmable 50%-duty clock divider with per-period tick
//            and glitch-free ratio change through a valid/ready handshake.
//            Optional macro CLK_DIV_CTRL_GATE_EN adds a gate_en input.
// Revision : 1.0
// ============================================================================
module clk_div_ctrl #(
    parameter int WIDTH   = 4,
    parameter int N_RESET = 5
) (
    input  logic             clk,
    input  logic             reset,
`ifdef CLK_DIV_CTRL_GATE_EN
    input  logic             gate_en,
`endif
    input  logic             req_valid,
    input  logic [WIDTH-1:0] req_div,
    output logic             req_ready,
    output logic             req_err,
    output logic [WIDTH-1:0] cur_div,
    output logic             clk_out,
    output logic             tick
);

    localparam logic [WIDTH-1:0] c_n_reset = WIDTH'(N_RESET);
    localparam logic [WIDTH-1:0] c_one     = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_two     = WIDTH'(2);

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] cur_div_q, cur_div_d;
    logic [WIDTH-1:0] pend_div_q, pend_div_d;
    logic             pend_q, pend_d;
    logic             hi_p_q, hi_p_d;
    logic             hi_n_q;
    logic             tick_q, tick_d;
    logic             req_err_q, req_err_d;

    logic             w_run;
    logic             w_boundary;
    logic             w_apply;
    logic             w_frozen;
    logic [WIDTH-1:0] w_div_eff;
    logic [WIDTH-1:0] w_half;

`ifdef CLK_DIV_CTRL_GATE_EN
    assign w_run = gate_en;
`else
    assign w_run = 1'b1;
`endif

    always_comb begin
        w_boundary = (count_q == (cur_div_q - c_one));
        w_apply    = w_boundary & pend_q;
        w_frozen   = w_boundary & ~w_run;
        w_div_eff  = w_apply ? pend_div_q : cur_div_q;
        w_half     = w_div_eff >> 1;

        count_d    = w_boundary ? '0 : (count_q + c_one);
        hi_p_d     = (count_d < w_half);
        tick_d     = (count_d == '0);
        // A gated divider parks on the boundary so re-enable starts a full period.
        if (w_frozen) begin
            count_d = w_div_eff - c_one;
            hi_p_d  = 1'b0;
            tick_d  = 1'b0;
        end

        cur_div_d  = cur_div_q;
        pend_d     = pend_q;
        pend_div_d = pend_div_q;
        req_err_d  = 1'b0;
        if (w_apply) begin
            cur_div_d = pend_div_q;
            pend_d    = 1'b0;
        end
        // Acceptance only happens with pend_q low, so it never collides with apply.
        if (req_valid && !pend_q) begin
            if (req_div >= c_two) begin
                pend_d     = 1'b1;
                pend_div_d = req_div;
            end else begin
                req_err_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q    <= c_n_reset - c_one;
            cur_div_q  <= c_n_reset;
            pend_div_q <= '0;
            pend_q     <= 1'b0;
            hi_p_q     <= 1'b0;
            tick_q     <= 1'b0;
            req_err_q  <= 1'b0;
        end else begin
            count_q    <= count_d;
            cur_div_q  <= cur_div_d;
            pend_div_q <= pend_div_d;
            pend_q     <= pend_d;
            hi_p_q     <= hi_p_d;
            tick_q     <= tick_d;
            req_err_q  <= req_err_d;
        end
    end

    // Half-cycle extension of the high phase, used only for odd ratios.
    always_ff @(negedge clk) begin
        if (reset) begin
            hi_n_q <= 1'b0;
        end else begin
            hi_n_q <= hi_p_q;
        end
    end

    assign clk_out   = hi_p_q | (cur_div_q[0] & hi_n_q);
    assign tick      = tick_q;
    assign cur_div   = cur_div_q;
    assign req_ready = ~pend_q;
    assign req_err   = req_err_q;

endmodule
`default_nettype wire

// File: tb/tb_clk_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_clk_div_ctrl
// Brief    : Directed self-checking bench for clk_div_ctrl (WIDTH=4, N_RESET=5).
// Revision : 1.0
// ============================================================================
module tb_clk_div_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       gate_en;
    logic       req_valid;
    logic [3:0] req_div;
    logic       req_ready;
    logic       req_err;
    logic [3:0] cur_div;
    logic       clk_out;
    logic       tick;

    int n_vec = 0;
    int n_err = 0;
    bit g_carry = 1'b0;

    always #5 clk = ~clk;

    clk_div_ctrl #(.WIDTH(4), .N_RESET(5)) u_dut (
        .clk       (clk),
        .reset     (reset),
`ifdef CLK_DIV_CTRL_GATE_EN
        .gate_en   (gate_en),
`endif
        .req_valid (req_valid),
        .req_div   (req_div),
        .req_ready (req_ready),
        .req_err   (req_err),
        .cur_div   (cur_div),
        .clk_out   (clk_out),
        .tick      (tick)
    );

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Entered at posedge+2 of the first cycle of a period of ratio n; leaves at
    // posedge+2 of the next period. clk_out must be high for the first n of the
    // 2n half-cycles. Optionally offers req_val during cycle req_at.
    task automatic check_period(input int n, input int req_at, input int req_val);
        logic pend_exp;
        pend_exp = g_carry;
        for (int i = 0; i < n; i++) begin
            req_valid = 1'b0;
            check($sformatf("tick n%0d i%0d", n, i), 16'(tick), 16'(i == 0));
            check($sformatf("clk_hi n%0d i%0d", n, i), 16'(clk_out), 16'(2*i < n));
            check($sformatf("cur_div n%0d i%0d", n, i), 16'(cur_div), 16'(n));
            check($sformatf("ready n%0d i%0d", n, i), 16'(req_ready), 16'(!pend_exp));
            check($sformatf("err n%0d i%0d", n, i), 16'(req_err),
                  16'(req_at >= 0 && req_val < 2 && i == req_at + 1));
            if (i == req_at) begin
                req_valid = 1'b1;
                req_div   = 4'(req_val);
            end
            @(negedge clk); #2;
            check($sformatf("clk_lo n%0d i%0d", n, i), 16'(clk_out), 16'(2*i + 1 < n));
            @(posedge clk); #2;
            if (i == req_at && req_val >= 2) pend_exp = 1'b1;
        end
        g_carry = (req_at == n - 1 && req_val >= 2);
    endtask

    initial begin
        reset     = 1'b1;
        gate_en   = 1'b1;
        req_valid = 1'b0;
        req_div   = 4'd0;

        repeat (3) @(posedge clk);
        #2;
        check("rst tick", 16'(tick), 16'd0);
        check("rst clk_out", 16'(clk_out), 16'd0);
        check("rst ready", 16'(req_ready), 16'd1);
        check("rst err", 16'(req_err), 16'd0);
        check("rst cur_div", 16'(cur_div), 16'd5);
        reset = 1'b0;
        @(posedge clk); #2;

        check_period(5, -1, 0);
        check_period(5, -1, 0);
        // Change to 4 requested mid-period at count 2
        check_period(5, 2, 4);
        check_period(4, -1, 0);
        check_period(4, -1, 0);
        check_period(4, 1, 5);
        check_period(5, -1, 0);
        // Request accepted in the boundary cycle waits one extra period
        check_period(5, 4, 3);
        check_period(5, -1, 0);
        check_period(3, -1, 0);
        check_period(3, -1, 0);
        check_period(3, 0, 5);
        // Invalid ratio is discarded with an error pulse
        check_period(5, 1, 1);
        check_period(5, -1, 0);
        // Same-ratio request completes with no visible change
        check_period(5, 2, 5);
        check_period(5, -1, 0);

        // Reset mid-period with a pending change to 7
        req_valid = 1'b1;
        req_div   = 4'd7;
        @(posedge clk); #2;
        req_valid = 1'b0;
        check("mid pend ready", 16'(req_ready), 16'd0);
        @(posedge clk); #2;
        reset = 1'b1;
        @(posedge clk); #2;
        check("mid rst clk_out", 16'(clk_out), 16'd0);
        check("mid rst tick", 16'(tick), 16'd0);
        check("mid rst ready", 16'(req_ready), 16'd1);
        check("mid rst cur_div", 16'(cur_div), 16'd5);
        @(negedge clk); #2;
        check("mid rst clk_lo", 16'(clk_out), 16'd0);
        @(posedge clk); #2;
        reset   = 1'b0;
        g_carry = 1'b0;
        @(posedge clk); #2;
        check_period(5, -1, 0);
        check_period(5, -1, 0);

`ifdef CLK_DIV_CTRL_GATE_EN
        gate_en = 1'b0;
        check_period(5, -1, 0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("gate tick %0d", k), 16'(tick), 16'd0);
            check($sformatf("gate clk_hi %0d", k), 16'(clk_out), 16'd0);
            check($sformatf("gate cur_div %0d", k), 16'(cur_div), 16'd5);
            @(negedge clk); #2;
            check($sformatf("gate clk_lo %0d", k), 16'(clk_out), 16'd0);
            @(posedge clk); #2;
        end
        gate_en = 1'b1;
        @(posedge clk); #2;
        check_period(5, -1, 0);
`endif

        req_valid = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
